bp_burst_to_wormhole: RTL and testbench

Converts a BedRock Burst stream into a wormhole router flit stream. It serializes the combined wormhole+protocol header and then the protocol data beats onto a `flit_width_p` link. It sits directly upstream of the wormhole network injection port and is the mirror image of the wormhole-to-burst converter at the network egress. Narrow protocol data is packed into flits, and wide protocol data is split across flits.

---
 rtl/bp_me_pkg.sv | 11 +
 rtl/bsg_parallel_in_serial_out.sv | 63 ++++++
 rtl/bp_burst_to_wormhole.sv | 205 ++++++++++++++++++++
 tb/tb_bp_burst_to_wormhole.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_me_pkg.sv
// Shared BedRock ME types for the burst/wormhole converters.
// Holds the converter state encoding.
package bp_me_pkg;

  typedef enum logic [1:0] {
    e_ready,
    e_hdr,
    e_data
  } bp_me_state_e;

endpackage

// File: rtl/bsg_parallel_in_serial_out.sv
// One-entry parallel-in serial-out buffer, LSB flit first.
// Ports: clk_i, reset_i; valid_i/data_i/ready_and_o in;
// valid_o/data_o/last_o/yumi_i out (yumi only while valid_o).
module bsg_parallel_in_serial_out #(
  parameter int width_p = 64,
  parameter int els_p   = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       valid_i,
  input  logic [els_p*width_p-1:0]   data_i,
  output logic                       ready_and_o,
  output logic                       valid_o,
  output logic [width_p-1:0]         data_o,
  output logic                       last_o,
  input  logic                       yumi_i
);

  localparam int cw_lp = (els_p > 1) ? $clog2(els_p) : 1;

  logic                     full_q, full_d;
  logic [els_p*width_p-1:0] data_q, data_d;
  logic [cw_lp-1:0]         cnt_q, cnt_d;

  assign last_o  = full_q & (cnt_q == cw_lp'(els_p - 1));
  // Refill in the same cycle the final flit leaves.
  assign ready_and_o = ~full_q | (yumi_i & last_o);
  assign valid_o = full_q;
  assign data_o  = data_q[width_p-1:0];

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    if (yumi_i & full_q) begin
      if (last_o) begin
        full_d = 1'b0;
        cnt_d  = '0;
      end else begin
        cnt_d  = cnt_q + cw_lp'(1);
        data_d = data_q >> width_p;
      end
    end
    if (valid_i & ready_and_o) begin
      full_d = 1'b1;
      cnt_d  = '0;
      data_d = data_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      full_q <= 1'b0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/bp_burst_to_wormhole.sv
// BedRock Burst to wormhole flit converter (header then data).
// Ports: pr_hdr_*, pr_data_*, pr_last_i in; link_* out.
module bp_burst_to_wormhole
  import bp_me_pkg::*;
#(
  parameter int flit_width_p    = 64,
  parameter int cord_width_p    = 0,
  parameter int len_width_p     = 8,
  parameter int cid_width_p     = 0,
  parameter int pr_hdr_width_p  = 56,
  parameter int pr_data_width_p = 64,
  parameter int hdr_width_p =
    cord_width_p + len_width_p + cid_width_p + pr_hdr_width_p
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [hdr_width_p-1:0]     pr_hdr_i,
  input  logic                       pr_hdr_v_i,
  output logic                       pr_hdr_ready_and_o,
  input  logic                       pr_has_data_i,
  input  logic [pr_data_width_p-1:0] pr_data_i,
  input  logic                       pr_data_v_i,
  output logic                       pr_data_ready_and_o,
  input  logic                       pr_last_i,
  output logic [flit_width_p-1:0]    link_data_o,
  output logic                       link_v_o,
  input  logic                       link_ready_and_i
);

  localparam bit wide_lp    = (pr_data_width_p >= flit_width_p);
  localparam int hdr_len_lp = hdr_width_p / flit_width_p;
  localparam int hcw_lp     = (hdr_len_lp > 1) ? $clog2(hdr_len_lp) : 1;

  if ((hdr_width_p % flit_width_p) != 0
      || (wide_lp ? (pr_data_width_p % flit_width_p)
                  : (flit_width_p % pr_data_width_p)) != 0)
  begin : g_bad_cfg
    $fatal(1, "bp_burst_to_wormhole: unsupported widths");
  end

  bp_me_state_e state_q, state_d;

  logic [hdr_width_p-1:0]  hdr_q, hdr_d;
  logic [hcw_lp-1:0]       hcnt_q, hcnt_d;
  logic                    has_data_q, has_data_d;
  logic                    last_q, last_d;
  logic [len_width_p-1:0]  fcnt_q, len_q;

  logic                    in_data;
  logic                    dv, dlast, dready;
  logic [flit_width_p-1:0] dflit;
  logic                    data_yumi, data_hs;
  logic                    link_hs, end_msg;

  assign in_data   = (state_q == e_data);
  assign data_yumi = in_data & dv & link_ready_and_i;
  // Once the last beat is inside, hold off the next message's beats.
  assign pr_data_ready_and_o = in_data & ~last_q & dready;
  assign data_hs = pr_data_v_i & pr_data_ready_and_o;
  assign link_hs = link_v_o & link_ready_and_i;
  assign end_msg = link_hs & (state_d == e_ready);

  if (wide_lp) begin : g_wide
    localparam int data_len_lp = pr_data_width_p / flit_width_p;

    bsg_parallel_in_serial_out #(
      .width_p (flit_width_p),
      .els_p   (data_len_lp)
    ) u_piso (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .valid_i     (pr_data_v_i & in_data & ~last_q),
      .data_i      (pr_data_i),
      .ready_and_o (dready),
      .valid_o     (dv),
      .data_o      (dflit),
      .last_o      (dlast),
      .yumi_i      (data_yumi)
    );
  end else begin : g_narrow
    localparam int els_lp = flit_width_p / pr_data_width_p;
    localparam int scw_lp = (els_lp > 1) ? $clog2(els_lp) : 1;

    logic [flit_width_p-1:0] flit_q, flit_d;
    logic [scw_lp-1:0]       slot_q, slot_d;
    logic                    fv_q, fv_d;

    assign dv     = fv_q;
    assign dflit  = flit_q;
    assign dlast  = 1'b1;
    assign dready = ~fv_q | link_ready_and_i;

    always_comb begin
      flit_d = flit_q;
      slot_d = slot_q;
      fv_d   = fv_q;
      if (data_yumi) begin
        fv_d = 1'b0;
      end
      if (data_hs) begin
        // Slot 0 starts a fresh flit so unfilled slots read zero.
        if (slot_q == '0) begin
          flit_d = '0;
        end
        flit_d[slot_q*pr_data_width_p +: pr_data_width_p] = pr_data_i;
        if (slot_q == scw_lp'(els_lp - 1) || pr_last_i) begin
          fv_d   = 1'b1;
          slot_d = '0;
        end else begin
          slot_d = slot_q + scw_lp'(1);
        end
      end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        flit_q <= '0;
        slot_q <= '0;
        fv_q   <= 1'b0;
      end else begin
        flit_q <= flit_d;
        slot_q <= slot_d;
        fv_q   <= fv_d;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    hdr_d      = hdr_q;
    hcnt_d     = hcnt_q;
    has_data_d = has_data_q;
    last_d     = last_q;
    pr_hdr_ready_and_o = 1'b0;
    link_v_o    = 1'b0;
    link_data_o = '0;
    unique case (state_q)
      e_ready: begin
        pr_hdr_ready_and_o = 1'b1;
        if (pr_hdr_v_i) begin
          hdr_d      = pr_hdr_i;
          has_data_d = pr_has_data_i;
          hcnt_d     = '0;
          last_d     = 1'b0;
          state_d    = e_hdr;
        end
      end
      e_hdr: begin
        link_v_o    = 1'b1;
        link_data_o = hdr_q[flit_width_p-1:0];
        if (link_ready_and_i) begin
          hdr_d  = hdr_q >> flit_width_p;
          hcnt_d = hcnt_q + hcw_lp'(1);
          if (hcnt_q == hcw_lp'(hdr_len_lp - 1)) begin
            state_d = has_data_q ? e_data : e_ready;
          end
        end
      end
      e_data: begin
        link_v_o    = dv;
        link_data_o = dflit;
        if (data_hs & pr_last_i) begin
          last_d = 1'b1;
        end
        if (data_yumi & dlast & last_q) begin
          last_d  = 1'b0;
          state_d = e_ready;
        end
      end
      default: state_d = e_ready;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= e_ready;
      hdr_q      <= '0;
      hcnt_q     <= '0;
      has_data_q <= 1'b0;
      last_q     <= 1'b0;
      fcnt_q     <= '0;
      len_q      <= '0;
    end else begin
      state_q    <= state_d;
      hdr_q      <= hdr_d;
      hcnt_q     <= hcnt_d;
      has_data_q <= has_data_d;
      last_q     <= last_d;
      if (pr_hdr_v_i & pr_hdr_ready_and_o) begin
        fcnt_q <= '0;
        len_q  <= pr_hdr_i[cord_width_p +: len_width_p];
      end else if (link_hs) begin
        fcnt_q <= fcnt_q + len_width_p'(1);
      end
    end
  end

  // The len field is trusted, not computed; flag a header that lies.
  always_ff @(posedge clk_i) begin
    if (!reset_i && end_msg) begin
      assert (fcnt_q == len_q);
    end
  end

endmodule

// File: tb/tb_bp_burst_to_wormhole.sv
// Bench for bp_burst_to_wormhole: wide (512b) and narrow (32b)
// instances against a flit-queue model of the message format.
module tb_bp_burst_to_wormhole;

  localparam int FW  = 64;
  localparam int HW  = 128;
  localparam int WDW = 512;
  localparam int NDW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [HW-1:0]  hdr = '0;
  logic           has_data = 1'b0;
  logic           hdr_v = 1'b0;
  logic [WDW-1:0] data = '0;
  logic           data_v = 1'b0;
  logic           last = 1'b0;
  logic           link_rdy = 1'b1;
  int             sel = 0;
  int             rdy_mode = 0;

  logic          w_hdr_rdy, w_data_rdy, w_link_v;
  logic [FW-1:0] w_link_d;
  logic          n_hdr_rdy, n_data_rdy, n_link_v;
  logic [FW-1:0] n_link_d;
  logic          hdr_rdy_s, data_rdy_s;

  assign hdr_rdy_s  = (sel == 1) ? n_hdr_rdy : w_hdr_rdy;
  assign data_rdy_s = (sel == 1) ? n_data_rdy : w_data_rdy;

  bp_burst_to_wormhole #(
    .flit_width_p(FW), .cord_width_p(8), .len_width_p(8),
    .cid_width_p(4), .pr_hdr_width_p(108), .pr_data_width_p(WDW)
  ) u_wide (
    .clk_i(clk), .reset_i(rst),
    .pr_hdr_i(hdr), .pr_hdr_v_i(hdr_v && (sel == 0)),
    .pr_hdr_ready_and_o(w_hdr_rdy), .pr_has_data_i(has_data),
    .pr_data_i(data), .pr_data_v_i(data_v && (sel == 0)),
    .pr_data_ready_and_o(w_data_rdy), .pr_last_i(last),
    .link_data_o(w_link_d), .link_v_o(w_link_v),
    .link_ready_and_i(link_rdy)
  );

  bp_burst_to_wormhole #(
    .flit_width_p(FW), .cord_width_p(8), .len_width_p(8),
    .cid_width_p(4), .pr_hdr_width_p(108), .pr_data_width_p(NDW)
  ) u_narrow (
    .clk_i(clk), .reset_i(rst),
    .pr_hdr_i(hdr), .pr_hdr_v_i(hdr_v && (sel == 1)),
    .pr_hdr_ready_and_o(n_hdr_rdy), .pr_has_data_i(has_data),
    .pr_data_i(data[NDW-1:0]), .pr_data_v_i(data_v && (sel == 1)),
    .pr_data_ready_and_o(n_data_rdy), .pr_last_i(last),
    .link_data_o(n_link_d), .link_v_o(n_link_v),
    .link_ready_and_i(link_rdy)
  );

  logic [FW-1:0]  exp0[$], exp1[$], log0[$], log1[$];
  int             logc0[$], logc1[$];
  logic [WDW-1:0] beats[$];
  int             n_chk = 0;
  int             n_fail = 0;
  bit             stall_v[2];
  logic [FW-1:0]  stall_d[2];

  task automatic check(input string nm, input logic [FW-1:0] act,
                       input logic [FW-1:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  function automatic logic [FW-1:0] lg(input int i, input int k);
    if (i == 0) return (k < log0.size()) ? log0[k] : 'x;
    return (k < log1.size()) ? log1[k] : 'x;
  endfunction

  function automatic int lc(input int i, input int k);
    if (i == 0) return (k < logc0.size()) ? logc0[k] : -1;
    return (k < logc1.size()) ? logc1[k] : -1;
  endfunction

  // Per-cycle compare: stability while stalled, and every
  // accepted flit against the model queue.
  task automatic chk(input int i, input logic v, input logic [FW-1:0] d);
    logic [FW-1:0] e;
    bit emp;
    e = '0;
    emp = 1'b0;
    if (stall_v[i]) begin
      n_chk++;
      if (!v || d !== stall_d[i]) begin
        n_fail++;
        $display("FAIL stall%0d: v=%b d=%h held %h", i, v, d, stall_d[i]);
      end
    end
    stall_v[i] = v && !link_rdy;
    stall_d[i] = d;
    if (v && link_rdy) begin
      if (i == 0) begin
        if (exp0.size() == 0) emp = 1'b1;
        else e = exp0.pop_front();
        log0.push_back(d);
        logc0.push_back(cyc);
      end else begin
        if (exp1.size() == 0) emp = 1'b1;
        else e = exp1.pop_front();
        log1.push_back(d);
        logc1.push_back(cyc);
      end
      n_chk++;
      if (emp) begin
        n_fail++;
        $display("FAIL unexpected%0d: got %h want none", i, d);
      end else if (d !== e) begin
        n_fail++;
        $display("FAIL flit%0d: got %h want %h", i, d, e);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      stall_v[0] = 1'b0;
      stall_v[1] = 1'b0;
    end else begin
      chk(0, w_link_v, w_link_d);
      chk(1, n_link_v, n_link_d);
    end
  end

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) link_rdy = 1'b1;
    else link_rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
  end

  // Message model: header flits low first, then wide beats split
  // LSB first or narrow beats packed two per flit, zero padded.
  task automatic build(input int s, input logic [107:0] ph,
                       input bit hd, input int nb,
                       output logic [HW-1:0] h);
    int nd;
    logic [FW-1:0] f;
    logic [FW-1:0] q[$];
    if (!hd) nd = 0;
    else if (s == 0) nd = 8 * nb;
    else nd = (nb + 1) / 2;
    h = {ph, 4'h0, 8'(2 + nd - 1), 8'h05};
    q.push_back(h[63:0]);
    q.push_back(h[127:64]);
    if (hd && s == 0) begin
      for (int b = 0; b < nb; b++)
        for (int j = 0; j < 8; j++) q.push_back(beats[b][64*j +: 64]);
    end else if (hd) begin
      f = '0;
      for (int b = 0; b < nb; b++) begin
        f = f | (64'(beats[b][31:0]) << (32 * (b % 2)));
        if ((b % 2) == 1 || b == nb - 1) begin
          q.push_back(f);
          f = '0;
        end
      end
    end
    foreach (q[k]) begin
      if (s == 0) exp0.push_back(q[k]);
      else exp1.push_back(q[k]);
    end
  endtask

  // st: 0 handshake, 1 aborted by reset, 2 timeout
  task automatic wait_rdy(input bit is_hdr, output int st, output int c);
    st = 2;
    c = -1;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (rst) begin
        st = 1;
        return;
      end
      if (is_hdr ? hdr_rdy_s : data_rdy_s) begin
        st = 0;
        c = cyc;
        return;
      end
    end
    n_chk++;
    n_fail++;
    $display("FAIL timeout: got no %s ready want ready",
             is_hdr ? "hdr" : "data");
  endtask

  task automatic send_msg(input int s, input logic [107:0] ph,
                          input bit hd, input int nb, output int hc);
    logic [HW-1:0] h;
    int st, c;
    sel = s;
    build(s, ph, hd, nb, h);
    hdr = h;
    has_data = hd;
    hdr_v = 1'b1;
    wait_rdy(1'b1, st, hc);
    if (st == 0) begin
      @(posedge clk);
      #1;
    end
    hdr_v = 1'b0;
    if (st != 0 || !hd) return;
    for (int b = 0; b < nb; b++) begin
      data = beats[b];
      last = (b == nb - 1);
      data_v = 1'b1;
      wait_rdy(1'b0, st, c);
      if (st != 0) break;
      @(posedge clk);
      #1;
    end
    data_v = 1'b0;
    last = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 300; t++) begin
      @(posedge clk);
      #1;
      if (exp0.size() == 0 && exp1.size() == 0) break;
    end
    check("drain", 64'(exp0.size() + exp1.size()), 64'd0);
  endtask

  task automatic clr_logs();
    log0.delete();
    log1.delete();
    logc0.delete();
    logc1.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hc, hc2;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_w_v", 64'(w_link_v), 64'd0);
    check("rst_w_hrdy", 64'(w_hdr_rdy), 64'd1);
    check("rst_w_drdy", 64'(w_data_rdy), 64'd0);
    check("rst_w_data", w_link_d, 64'd0);
    check("rst_n_v", 64'(n_link_v), 64'd0);
    check("rst_n_hrdy", 64'(n_hdr_rdy), 64'd1);
    check("rst_n_drdy", 64'(n_data_rdy), 64'd0);
    check("rst_n_data", n_link_d, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Header only, wide instance
    clr_logs();
    send_msg(0, 108'hAAAA_BBBB, 1'b0, 0, hc);
    drain();
    check("hdr_only_n", 64'(log0.size()), 64'd2);
    check("hdr_only_f0", lg(0, 0), 64'h000A_AAAB_BBB0_0105);
    check("hdr_only_f1", lg(0, 1), 64'h0);
    check("hdr_latency", 64'(lc(0, 0)), 64'(hc + 1));
    check("hdr_only_ready", 64'(w_hdr_rdy), 64'd1);

    // Wide, two beats, constant ready
    clr_logs();
    beats.delete();
    for (int b = 0; b < 2; b++) begin
      logic [WDW-1:0] bt;
      for (int j = 0; j < 8; j++) bt[64*j +: 64] = {32'(32'hB0 + b), 32'(j)};
      beats.push_back(bt);
    end
    send_msg(0, 108'h1234, 1'b1, 2, hc);
    drain();
    check("wide_n", 64'(log0.size()), 64'd18);
    check("wide_b0f0", lg(0, 2), 64'h0000_00B0_0000_0000);
    check("wide_b0f2", lg(0, 4), 64'h0000_00B0_0000_0002);
    check("wide_b1f0", lg(0, 10), 64'h0000_00B1_0000_0000);
    check("wide_b1f7", lg(0, 17), 64'h0000_00B1_0000_0007);
    check("wide_hdr_gap", 64'(lc(0, 1) - lc(0, 0)), 64'd1);
    check("wide_data_gap", 64'(lc(0, 17) - lc(0, 2)), 64'd15);

    // Wide, link ready pattern 1,0,0,1
    clr_logs();
    beats.delete();
    for (int b = 0; b < 2; b++) begin
      logic [WDW-1:0] bt;
      for (int j = 0; j < 8; j++) bt[64*j +: 64] = {32'(32'hC0 + b), 32'(j + 16)};
      beats.push_back(bt);
    end
    rdy_mode = 1;
    send_msg(0, 108'h5678, 1'b1, 2, hc);
    drain();
    rdy_mode = 0;
    check("stall_n", 64'(log0.size()), 64'd18);
    check("stall_b1f3", lg(0, 13), 64'h0000_00C1_0000_0013);

    // Narrow, three beats
    clr_logs();
    beats.delete();
    beats.push_back(512'h11);
    beats.push_back(512'h22);
    beats.push_back(512'h33);
    send_msg(1, 108'h9, 1'b1, 3, hc);
    drain();
    check("narrow_n", 64'(log1.size()), 64'd4);
    check("narrow_f0", lg(1, 2), 64'h0000_0022_0000_0011);
    check("narrow_f1", lg(1, 3), 64'h0000_0000_0000_0033);
    check("narrow_ready", 64'(n_hdr_rdy), 64'd1);

    // Second header offered while first message is in e_data
    clr_logs();
    beats.delete();
    beats.push_back(512'h44);
    beats.push_back(512'h55);
    beats.push_back(512'h66);
    fork
      send_msg(1, 108'h1, 1'b1, 3, hc);
      begin
        repeat (4) @(posedge clk);
        #1;
        send_msg(1, 108'h2, 1'b0, 0, hc2);
      end
    join
    drain();
    check("hdr2_n", 64'(log1.size()), 64'd6);
    check("hdr2_accept", 64'(hc2), 64'(lc(1, 3) + 1));
    check("hdr2_f0", lg(1, 2), 64'h0000_0055_0000_0044);

    // Reset during the 5th data flit
    clr_logs();
    beats.delete();
    beats.push_back({8{64'hDEAD_0000_0000_0001}});
    beats.push_back({8{64'hDEAD_0000_0000_0002}});
    fork
      send_msg(0, 108'h77, 1'b1, 2, hc);
      begin
        for (int t = 0; t < 300; t++) begin
          @(negedge clk);
          #1;
          if (log0.size() >= 6) break;
        end
        @(posedge clk);
        #2;
        check("pre_rst_v", 64'(w_link_v), 64'd1);
        rst = 1'b1;
        exp0.delete();
        #1;
        check("async_rst_v", 64'(w_link_v), 64'd0);
        check("async_rst_d", w_link_d, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
      end
    join
    repeat (3) begin
      @(posedge clk);
      #1;
      check("post_rst_v", 64'(w_link_v), 64'd0);
    end
    check("post_rst_hrdy", 64'(w_hdr_rdy), 64'd1);
    check("post_rst_drdy", 64'(w_data_rdy), 64'd0);
    clr_logs();
    beats.delete();
    beats.push_back({8{64'hBEEF_0000_0000_00AA}});
    send_msg(0, 108'h88, 1'b1, 1, hc);
    drain();
    check("post_rst_n", 64'(log0.size()), 64'd10);
    check("post_rst_f2", lg(0, 2), 64'hBEEF_0000_0000_00AA);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
